// File: rtl/serial_proto_pkg.sv
// rtl/serial_proto_pkg.sv - line constants and FSM encoding shared by both ends of the serial link
package serial_proto_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/parity_calc.sv
// rtl/parity_calc.sv - parity reduction over one data word, odd or even by parameter
module parity_calc #(
  parameter int WIDTH      = 8,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic [WIDTH-1:0] data_i,
  output logic             parity_o
);

  // Odd parity makes data plus parity carry an odd number of ones.
  assign parity_o = ODD_PARITY ? ~^data_i : ^data_i;

endmodule

// File: rtl/serial_tx_odd_parity.sv
// rtl/serial_tx_odd_parity.sv - one-bit-per-clock frame transmitter: start, data LSB first, parity, stop
module serial_tx_odd_parity
  import serial_proto_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter bit ODD_PARITY = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int              CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 done_q, done_d;
  logic                 par_calc;
  logic                 take;

  parity_calc #(
    .WIDTH      (DATA_BITS),
    .ODD_PARITY (ODD_PARITY)
  ) u_parity (
    .data_i   (in_data),
    .parity_o (par_calc)
  );

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STOP);
  assign take     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= IDLE_LEVEL;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    parity_d = parity_q;
    unique case (state_q)
      ST_IDLE: begin
        if (take) begin
          state_d  = ST_START;
          shift_d  = in_data;
          parity_d = par_calc;
        end
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == LAST_BIT) begin
          state_d = ST_PARITY;
          cnt_d   = '0;
        end else begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_PARITY: state_d = ST_STOP;
      ST_STOP: begin
        if (take) begin
          state_d  = ST_START;
          shift_d  = in_data;
          parity_d = par_calc;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line level is decoded from the next state so tx comes straight from a flop.
  always_comb begin
    tx_d   = IDLE_LEVEL;
    done_d = 1'b0;
    unique case (state_d)
      ST_START:  tx_d = START_BIT;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      ST_STOP: begin
        tx_d   = STOP_BIT;
        done_d = 1'b1;
      end
      default:   tx_d = IDLE_LEVEL;
    endcase
  end

  assign tx   = tx_q;
  assign done = done_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_serial_tx_odd_parity.sv
// tb/tb_serial_tx_odd_parity.sv - randomized self-checking bench with a frame-level reference model
`timescale 1ns/1ps
module tb_serial_tx_odd_parity;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, tx, busy, done;
  logic       ready_e, tx_e, busy_e, done_e;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int accept_count = 0;

  typedef struct {
    bit t_odd;
    bit t_even;
    bit stop;
  } slot_t;

  slot_t q[$];

  always #5 clk = ~clk;

  serial_tx_odd_parity #(.DATA_BITS(8), .ODD_PARITY(1'b1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
  );

  serial_tx_odd_parity #(.DATA_BITS(8), .ODD_PARITY(1'b0)) dut_e (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_e), .tx(tx_e), .busy(busy_e), .done(done_e)
  );

  // Reference: each accepted byte becomes a list of line levels, one per cycle.
  function automatic void push_frame(input logic [7:0] d);
    slot_t s;
    int    ones;
    ones = $countones(d);
    s.t_odd = 1'b0; s.t_even = 1'b0; s.stop = 1'b0;
    q.push_back(s);
    for (int i = 0; i < 8; i++) begin
      s.t_odd = d[i]; s.t_even = d[i]; s.stop = 1'b0;
      q.push_back(s);
    end
    s.t_odd = ((ones % 2) == 0); s.t_even = ((ones % 2) == 1); s.stop = 1'b0;
    q.push_back(s);
    s.t_odd = 1'b1; s.t_even = 1'b1; s.stop = 1'b1;
    q.push_back(s);
  endfunction

  logic [7:0] mon_got, mon_exp;
  bit         e_to, e_te, e_busy, e_done, e_ready;

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        e_to = q[0].t_odd; e_te = q[0].t_even; e_busy = 1'b1; e_done = q[0].stop;
      end else begin
        e_to = 1'b1; e_te = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      e_ready = (q.size() <= 1);
      mon_got = {tx, busy, done, in_ready, tx_e, busy_e, done_e, ready_e};
      mon_exp = {e_to, e_busy, e_done, e_ready, e_te, e_busy, e_done, e_ready};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL line_model t=%0t {tx,busy,done,rdy,tx_e,busy_e,done_e,rdy_e} got=%b exp=%b",
                 $time, mon_got, mon_exp);
      end
      if (reset) begin
        q.delete();
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        if (in_valid && e_ready) begin
          push_frame(in_data);
          accept_count++;
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] d);
    int start;
    start    = accept_count;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (accept_count != start) return;
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout data=%h got=no_accept_in_200 exp=accept", d);
  endtask

  task automatic capture_frame(output logic [7:0] d, output logic po, output logic pe,
                               output logic sb, output int busy_n, output int done_at);
    d = '0; po = 1'b0; pe = 1'b0; sb = 1'b1; busy_n = 0; done_at = -1;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done && done_at < 0) done_at = c;
      if (c == 1) sb = tx;
      if (c >= 2 && c <= 9) d[3'(c - 2)] = tx;
      if (c == 10) begin po = tx; pe = tx_e; end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({tx, busy, done, in_ready, tx_e, busy_e, done_e, ready_e} !== 8'b1001_1001) begin
      errors++;
      $display("FAIL reset_state got=%b exp=10011001",
               {tx, busy, done, in_ready, tx_e, busy_e, done_e, ready_e});
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_zero_byte();
    logic [7:0] d; logic po, pe, sb; int bn, da;
    drive_byte(8'h00);
    in_valid = 1'b0;
    capture_frame(d, po, pe, sb, bn, da);
    checks++; if (sb !== 1'b0) begin errors++; $display("FAIL zero_start got=%b exp=0", sb); end
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL zero_data got=%h exp=00", d); end
    checks++; if (po !== 1'b1) begin errors++; $display("FAIL zero_parity got=%b exp=1", po); end
    checks++; if (da != 11) begin errors++; $display("FAIL zero_done_cycle got=%0d exp=11", da); end
    checks++; if (bn != 11) begin errors++; $display("FAIL zero_busy_len got=%0d exp=11", bn); end
  endtask

  task automatic test_a5();
    logic [7:0] d; logic po, pe, sb; int bn, da;
    drive_byte(8'hA5);
    in_valid = 1'b0;
    in_data  = 8'h00;
    capture_frame(d, po, pe, sb, bn, da);
    checks++; if (d !== 8'hA5) begin errors++; $display("FAIL a5_data got=%h exp=a5", d); end
    checks++; if (po !== 1'b1) begin errors++; $display("FAIL a5_odd_parity got=%b exp=1", po); end
    checks++; if (pe !== 1'b0) begin errors++; $display("FAIL a5_even_parity got=%b exp=0", pe); end
  endtask

  task automatic test_back_to_back();
    int run; bit stopped; logic po1, po2, pe1, pe2, sb2;
    run = 0; stopped = 1'b0;
    po1 = 1'bx; po2 = 1'bx; pe1 = 1'bx; pe2 = 1'bx; sb2 = 1'bx;
    drive_byte(8'h01);
    fork
      begin
        drive_byte(8'h80);
        in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 24; c++) begin
          @(negedge clk);
          if (busy && !stopped) run++;
          else stopped = 1'b1;
          if (c == 10) begin po1 = tx; pe1 = tx_e; end
          if (c == 12) sb2 = tx;
          if (c == 21) begin po2 = tx; pe2 = tx_e; end
        end
      end
    join
    @(posedge clk); #1;
    checks++; if (run != 22) begin errors++; $display("FAIL b2b_busy_run got=%0d exp=22", run); end
    checks++; if (sb2 !== 1'b0) begin errors++; $display("FAIL b2b_second_start got=%b exp=0", sb2); end
    checks++; if ({po1, po2} !== 2'b00) begin errors++; $display("FAIL b2b_odd_parity got=%b exp=00", {po1, po2}); end
    checks++; if ({pe1, pe2} !== 2'b11) begin errors++; $display("FAIL b2b_even_parity got=%b exp=11", {pe1, pe2}); end
  endtask

  task automatic test_hold_during_data();
    int n, start; logic rdy; logic [7:0] d; logic po, pe, sb; int bn, da;
    n = 0;
    drive_byte(8'h5A);
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    in_data  = 8'h3C;
    in_valid = 1'b1;
    start    = accept_count;
    @(negedge clk);
    rdy = in_ready;
    while (accept_count == start && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_data  = 8'hFF;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL hold_ready_in_data got=%b exp=0", rdy); end
    checks++; if (n != 9) begin errors++; $display("FAIL hold_accept_edges got=%0d exp=9", n); end
    capture_frame(d, po, pe, sb, bn, da);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL hold_data got=%h exp=3c", d); end
    checks++; if ({sb, po, pe} !== 3'b010) begin errors++; $display("FAIL hold_start_par got=%b exp=010", {sb, po, pe}); end
  endtask

  task automatic test_reset_mid_frame();
    int dn; logic [7:0] d; logic po, pe, sb; int bn, da;
    dn = 0;
    drive_byte(8'hC3);
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset    = 1'b1;
    in_data  = 8'h77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx, busy, done, in_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL midreset_state got=%b exp=1001", {tx, busy, done, in_ready});
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL midreset_activity got=%0d exp=0", dn); end
    @(posedge clk); #1;
    drive_byte(8'h96);
    in_valid = 1'b0;
    capture_frame(d, po, pe, sb, bn, da);
    checks++; if (d !== 8'h96) begin errors++; $display("FAIL midreset_next_data got=%h exp=96", d); end
    checks++; if (po !== 1'b1 || da != 11) begin errors++; $display("FAIL midreset_next_frame got=par%b,done@%0d exp=par1,done@11", po, da); end
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 300; i++) begin
      drive_byte(8'($urandom));
      gap = $urandom_range(0, 16);
      if (gap > 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
      end
    end
    in_valid = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    @(negedge clk);
    checks++;
    if ({tx, busy} !== 2'b10) begin
      errors++;
      $display("FAIL random_drain {tx,busy} got=%b exp=10", {tx, busy});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    test_reset();
    test_zero_byte();
    test_a5();
    test_back_to_back();
    test_hold_during_data();
    test_reset_mid_frame();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
